// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the 7-segment scan driver (package seg_pkg).
package seg_pkg;

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} scan_state_t;

  localparam int SEG_W      = 7;
  localparam int MAX_DIGITS = 16;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;

  // All-ones enable vector at the widest supported bank; callers slice it down.
  function automatic logic [MAX_DIGITS-1:0] dig_off();
    return '1;
  endfunction

endpackage

// File: rtl/seg_scan_driver_hex_display.sv
// Hex nibble to 7-segment decoder, active-high segments, bit6..bit0 = a..g.
module hex_display
  import seg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] segment
);

  always_comb begin
    segment = SEG_OFF;
    case (nibble)
      4'h0: segment = 7'b1111110;
      4'h1: segment = 7'b0110000;
      4'h2: segment = 7'b1101101;
      4'h3: segment = 7'b1111001;
      4'h4: segment = 7'b0110011;
      4'h5: segment = 7'b1011011;
      4'h6: segment = 7'b1011111;
      4'h7: segment = 7'b1110000;
      4'h8: segment = 7'b1111111;
      4'h9: segment = 7'b1111011;
      4'hA: segment = 7'b1110111;
      4'hB: segment = 7'b0011111;
      4'hC: segment = 7'b1001110;
      4'hD: segment = 7'b0111101;
      4'hE: segment = 7'b1001111;
      4'hF: segment = 7'b1000111;
      default: segment = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with shadow capture and blanking gaps.
// Optional leading-zero suppression: define SEG_ZERO_SUPPRESS_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  update,
  output logic                  pending,
  output logic                  frame_start,
  output logic [DIGITS-1:0]     digit_en_n,
  output logic [SEG_W-1:0]      segment
);

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [MAX_DIGITS-1:0] DIG_ALL = dig_off();
  localparam logic [DIGITS-1:0]     DIG_OFF = DIG_ALL[DIGITS-1:0];

  scan_state_t         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] shown_q, shown_d;
  logic                pending_q, pending_d;
  logic                frame_start_q, frame_start_d;
  logic [DIGITS-1:0]   digit_en_n_q, digit_en_n_d;
  logic [SEG_W-1:0]    segment_q, segment_d;

  logic [3:0]          nibble;
  logic [SEG_W-1:0]    dec_seg;
  logic                lit;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    shown_d       = shown_q;
    pending_d     = pending_q;
    frame_start_d = 1'b0;
    case (state_q)
      BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = SHOW;
          cnt_d   = '0;
          if (idx_q == '0) begin
            frame_start_d = 1'b1;
            if (pending_q) begin
              shown_d   = shadow_q;
              pending_d = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == CNT_W'(ON_CYCLES - 1)) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    // A capture on the commit edge lands after the commit took the old shadow.
    if (update) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end
  end

  // Decode from next-state values so outputs stay registered yet track the commit.
  assign nibble = shown_d[{idx_d, 2'b00} +: 4];

  hex_display u_hex (
    .nibble  (nibble),
    .segment (dec_seg)
  );

`ifdef SEG_ZERO_SUPPRESS_EN
  logic [DIGITS-1:0] nz;
  logic [IDX_W-1:0]  hi;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nz
    assign nz[gi] = |shown_d[4*gi +: 4];
  end

  always_comb begin
    hi = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (nz[i]) hi = IDX_W'(i);
    end
  end

  assign lit = (idx_d <= hi);
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    digit_en_n_d = DIG_OFF;
    segment_d    = SEG_OFF;
    if (state_d == SHOW && lit) begin
      digit_en_n_d[idx_d] = 1'b0;
      segment_d           = dec_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BLANK;
      idx_q         <= '0;
      cnt_q         <= '0;
      shadow_q      <= '0;
      shown_q       <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      digit_en_n_q  <= DIG_OFF;
      segment_q     <= SEG_OFF;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      shown_q       <= shown_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      digit_en_n_q  <= digit_en_n_d;
      segment_q     <= segment_d;
    end
  end

  assign pending     = pending_q;
  assign frame_start = frame_start_q;
  assign digit_en_n  = digit_en_n_q;
  assign segment     = segment_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4-digit bank (ON=3, BLANK=2) plus a 1-digit bank.
module tb_seg_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        update;
  logic        pending;
  logic        frame_start;
  logic [3:0]  digit_en_n;
  logic [6:0]  segment;

  logic [3:0]  value1;
  logic        update1;
  logic        pending1;
  logic        frame_start1;
  logic [0:0]  digit_en_n1;
  logic [6:0]  segment1;

  int total = 0;
  int bad   = 0;

  seg_scan_driver #(.DIGITS(4), .ON_CYCLES(3), .BLANK_CYCLES(2)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .update      (update),
    .pending     (pending),
    .frame_start (frame_start),
    .digit_en_n  (digit_en_n),
    .segment     (segment)
  );

  seg_scan_driver #(.DIGITS(1), .ON_CYCLES(3), .BLANK_CYCLES(2)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .value       (value1),
    .update      (update1),
    .pending     (pending1),
    .frame_start (frame_start1),
    .digit_en_n  (digit_en_n1),
    .segment     (segment1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] hex_model(logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  function automatic bit lit_model(logic [15:0] v, int d);
`ifdef SEG_ZERO_SUPPRESS_EN
    int hi = 0;
    for (int i = 1; i < 4; i++) begin
      if (v[4*i +: 4] != 4'h0) hi = i;
    end
    return (d <= hi);
`else
    return 1'b1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame_start(int budget);
    int n = 0;
    while (frame_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    total++;
    assert (frame_start === 1'b1)
    else begin
      bad++;
      $error("FAIL frame_start_wait observed=%b expected=1 after %0d cycles", frame_start, n);
    end
  endtask

  task automatic post_update(logic [15:0] v);
    value  = v;
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  // Starts on the frame_start sample, ends on the last blank sample of the frame.
  task automatic check_frame(logic [15:0] v, string tag);
    for (int o = 0; o < 20; o++) begin
      int         d;
      bit         on;
      logic [3:0] e_en;
      logic [6:0] e_seg;
      if (o > 0) tick();
      d     = o / 5;
      on    = ((o % 5) < 3) && lit_model(v, d);
      e_en  = 4'hF;
      e_seg = 7'b0;
      if (on) begin
        e_en[d] = 1'b0;
        e_seg   = hex_model(v[4*d +: 4]);
      end
      chk($sformatf("%s_o%0d_en", tag, o), {28'b0, digit_en_n}, {28'b0, e_en});
      chk($sformatf("%s_o%0d_seg", tag, o), {25'b0, segment}, {25'b0, e_seg});
      chk($sformatf("%s_o%0d_fs", tag, o), {31'b0, frame_start}, {31'b0, (o == 0)});
    end
    $display("frame %s value=%h checked", tag, v);
  endtask

  initial begin
    rst     = 1'b1;
    value   = 16'h0;
    update  = 1'b0;
    value1  = 4'h0;
    update1 = 1'b0;
    repeat (3) tick();

    chk("rst_en", {28'b0, digit_en_n}, 32'hF);
    chk("rst_seg", {25'b0, segment}, 32'h0);
    chk("rst_pending", {31'b0, pending}, 32'h0);
    chk("rst_fs", {31'b0, frame_start}, 32'h0);
    chk("rst_en1", {31'b0, digit_en_n1}, 32'h1);

    rst = 1'b0;
    tick();
    chk("rel_e1_en", {28'b0, digit_en_n}, 32'hF);
    tick();
    chk("rel_e2_en", {28'b0, digit_en_n}, 32'hE);
    chk("rel_e2_fs", {31'b0, frame_start}, 32'h1);
    chk("rel_e2_seg", {25'b0, segment}, {25'b0, hex_model(4'h0)});

    // Reset in the middle of SHOW with a capture outstanding.
    post_update(16'hBEEF);
    chk("pre_rst_pending", {31'b0, pending}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_en", {28'b0, digit_en_n}, 32'hF);
    chk("midrst_seg", {25'b0, segment}, 32'h0);
    chk("midrst_pending", {31'b0, pending}, 32'h0);
    chk("midrst_fs", {31'b0, frame_start}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("rel2_e1_en", {28'b0, digit_en_n}, 32'hF);
    chk("rel2_e1_fs", {31'b0, frame_start}, 32'h0);
    tick();
    chk("rel2_e2_en", {28'b0, digit_en_n}, 32'hE);
    chk("rel2_e2_fs", {31'b0, frame_start}, 32'h1);
    chk("rel2_e2_seg", {25'b0, segment}, {25'b0, hex_model(4'h0)});
    tick();
    chk("rel2_e3_fs", {31'b0, frame_start}, 32'h0);

    // Update and commit.
    post_update(16'h1A2F);
    chk("upd_pending", {31'b0, pending}, 32'h1);
    wait_frame_start(25);
    chk("commit_pending_clr", {31'b0, pending}, 32'h0);
    check_frame(16'h1A2F, "f1A2F");

    // Update with pending clear on the frame edge is not committed this frame.
    post_update(16'h0003);
    chk("s3_pending", {31'b0, pending}, 32'h1);
    check_frame(16'h1A2F, "f1A2F_again");
    // Update landing on the commit edge: old shadow shown, new one stays pending.
    post_update(16'h0005);
    chk("simul_pending", {31'b0, pending}, 32'h1);
    check_frame(16'h0003, "f0003");
    tick();
    chk("simul_next_pending", {31'b0, pending}, 32'h0);
    check_frame(16'h0005, "f0005");

    // Last update wins.
    tick();
    tick();
    post_update(16'h1111);
    tick();
    tick();
    post_update(16'h2222);
    wait_frame_start(25);
    chk("lw_pending", {31'b0, pending}, 32'h0);
    check_frame(16'h2222, "f2222");

    // Leading zeros (suppressed only when the feature is built in).
    tick();
    post_update(16'h0040);
    wait_frame_start(25);
    check_frame(16'h0040, "f0040");
    tick();
    post_update(16'h0000);
    wait_frame_start(25);
    check_frame(16'h0000, "f0000");

    // Single-digit bank: 3 lit, 2 dark, frame_start every 5 clocks.
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    value1  = 4'h7;
    update1 = 1'b1;
    tick();
    update1 = 1'b0;
    chk("d1_o1_en", {31'b0, digit_en_n1}, 32'h1);
    chk("d1_o1_fs", {31'b0, frame_start1}, 32'h0);
    chk("d1_o1_pending", {31'b0, pending1}, 32'h1);
    for (int o = 2; o <= 16; o++) begin
      bit on;
      bit fs;
      tick();
      on = ((o - 2) % 5) < 3;
      fs = ((o - 2) % 5) == 0;
      chk($sformatf("d1_o%0d_en", o), {31'b0, digit_en_n1}, {31'b0, ~on});
      chk($sformatf("d1_o%0d_fs", o), {31'b0, frame_start1}, {31'b0, fs});
      chk($sformatf("d1_o%0d_seg", o), {25'b0, segment1}, on ? {25'b0, hex_model(4'h7)} : 32'h0);
    end
    chk("d1_pending_clr", {31'b0, pending1}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
